// File: rtl/decade_2421_display.sv
// decade_2421_display
// Converts a 2421 (Aiken) coded units digit into a two-digit BCD count and
// drives a two-digit multiplexed seven-segment display.
//
// Optional feature: define DECADE_2421_ERR_EN to build the sticky
// invalid-code flag on ERR. Without it ERR is tied to 0.
//
// Pipeline: CODE_IN -> code_q (stage 1) -> BCD_ONES/BCD_TENS (stage 2).
// A tens increment happens only when a valid 0 follows a registered 9.
// Invalid codes freeze the count, so 9 / invalid / 0 still counts once.
module decade_2421_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] CODE_IN,
    output logic [3:0] BCD_ONES,
    output logic [3:0] BCD_TENS,
    output logic       CARRY,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic       ERR
);

    localparam int          CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SCAN_TC = CW'(SCAN_DIV - 1);

    logic [3:0]    code_q;
    logic          dec_valid;
    logic [3:0]    dec_val;
    logic          wrap;
    logic [CW-1:0] scan_cnt;
    logic          sel;
    logic [3:0]    disp_digit;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD values blank.
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    // Stage 1: capture the upstream code.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            code_q <= 4'd0;
        end else begin
            code_q <= CODE_IN;
        end
    end

    // Aiken 2421 decode; the six unused codes are flagged invalid.
    always_comb begin
        dec_valid = 1'b1;
        dec_val   = 4'd0;
        case (code_q)
            4'b0000: dec_val = 4'd0;
            4'b0001: dec_val = 4'd1;
            4'b0010: dec_val = 4'd2;
            4'b0011: dec_val = 4'd3;
            4'b0100: dec_val = 4'd4;
            4'b1011: dec_val = 4'd5;
            4'b1100: dec_val = 4'd6;
            4'b1101: dec_val = 4'd7;
            4'b1110: dec_val = 4'd8;
            4'b1111: dec_val = 4'd9;
            default: dec_valid = 1'b0;
        endcase
    end

    assign wrap = dec_valid && (BCD_ONES == 4'd9) && (dec_val == 4'd0);

    // Stage 2: load units, advance tens on a 9->0 transition, pulse CARRY on tens wrap.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            BCD_ONES <= 4'd0;
            BCD_TENS <= 4'd0;
            CARRY    <= 1'b0;
        end else begin
            CARRY <= 1'b0;
            if (dec_valid) begin
                BCD_ONES <= dec_val;
                if (wrap) begin
                    if (BCD_TENS == 4'd9) begin
                        BCD_TENS <= 4'd0;
                        CARRY    <= 1'b1;
                    end else begin
                        BCD_TENS <= BCD_TENS + 4'd1;
                    end
                end
            end
        end
    end

    // Scan prescaler: dwell SCAN_DIV cycles per digit, then swap digits.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scan_cnt <= '0;
            sel      <= 1'b0;
        end else if (scan_cnt == SCAN_TC) begin
            scan_cnt <= '0;
            sel      <= ~sel;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign disp_digit = sel ? BCD_TENS : BCD_ONES;

    // Registered display drive; exactly one digit enable is ever low.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            AN  <= 2'b10;
            SEG <= 7'b1000000;
        end else begin
            AN  <= sel ? 2'b01 : 2'b10;
            SEG <= seg_pattern(disp_digit);
        end
    end

`ifdef DECADE_2421_ERR_EN
    logic err_q;

    // Sticky flag: any invalid registered code sets it until reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err_q <= 1'b0;
        end else if (!dec_valid) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule
